handshake_protocol_monitor: RTL and testbench

//  Passive, parametrised ready/valid protocol checker, bound alongside RTL under test.

---
 rtl/handshake_protocol_monitor_if.sv | 12 +
 rtl/handshake_protocol_monitor.sv | 156 +++++++++++++++
 tb/tb_handshake_protocol_monitor.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/handshake_protocol_monitor_if.sv
// Bundle of per-channel ready/valid handshakes; a passive observer only ever uses the slave view.
interface handshake_protocol_monitor_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
);
    logic [N_CH-1:0]        valid;
    logic [N_CH-1:0]        ready;
    logic [N_CH*DATA_W-1:0] data;

    modport master (output valid, output ready, output data);
    modport slave  (input  valid, input  ready, input  data);
endinterface

// File: rtl/handshake_protocol_monitor.sv
// Passive ready/valid checker: drop, payload-stability and stall checks plus transfer counts per channel.
// Violations at edge k are visible after edge k; observes only, never backpressures the bus.
module handshake_protocol_monitor #(
    parameter int  N_CH      = 4,
    parameter int  DATA_W    = 8,
    parameter int  MAX_STALL = 16,
    parameter int  CNT_W     = 16,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int SC_W      = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1
) (
    input  logic                      CLK,
    input  logic                      ASYNCRESETN,
    handshake_protocol_monitor_if.slave bus,
    input  logic                      clear,
    output logic [N_CH-1:0]           err_drop,
    output logic [N_CH-1:0]           err_data,
    output logic [N_CH-1:0]           err_stall,
    output logic                      err_any,
    output logic                      err_pulse,
    output logic [CH_W-1:0]           first_ch,
    output logic [1:0]                first_code,
    output logic [N_CH*CNT_W-1:0]     xfer_count
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [SC_W-1:0] STALL_MAX = SC_W'(MAX_STALL);
    localparam logic [SC_W-1:0] STALL_PRE = SC_W'(MAX_STALL - 1);

    state_t            state_q [N_CH];
    state_t            state_d [N_CH];
    logic [DATA_W-1:0] lat_q   [N_CH];
    logic [DATA_W-1:0] lat_d   [N_CH];
    logic [SC_W-1:0]   stall_q [N_CH];
    logic [SC_W-1:0]   stall_d [N_CH];
    logic [CNT_W-1:0]  cnt_q   [N_CH];

    logic [N_CH-1:0]   drop_ev;
    logic [N_CH-1:0]   data_ev;
    logic [N_CH-1:0]   stall_ev;
    logic              hit_any;
    logic [CH_W-1:0]   sel_ch;
    logic [1:0]        sel_code;

    always_comb begin
        drop_ev  = '0;
        data_ev  = '0;
        stall_ev = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            lat_d[i]   = lat_q[i];
            stall_d[i] = stall_q[i];
            case (state_q[i])
                IDLE: begin
                    if (bus.valid[i] && !bus.ready[i]) begin
                        state_d[i]  = WAIT;
                        lat_d[i]    = bus.data[i*DATA_W +: DATA_W];
                        stall_d[i]  = SC_W'(1);
                        stall_ev[i] = (MAX_STALL == 1);
                    end
                end
                WAIT: begin
                    if (!bus.valid[i]) begin
                        drop_ev[i] = 1'b1;
                        state_d[i] = IDLE;
                        stall_d[i] = '0;
                    end else begin
                        // re-latch so one glitch is reported once, not on every later cycle
                        if (bus.data[i*DATA_W +: DATA_W] != lat_q[i]) begin
                            data_ev[i] = 1'b1;
                            lat_d[i]   = bus.data[i*DATA_W +: DATA_W];
                        end
                        if (bus.ready[i]) begin
                            state_d[i] = IDLE;
                            stall_d[i] = '0;
                        end else if (stall_q[i] != STALL_MAX) begin
                            stall_d[i]  = stall_q[i] + 1'b1;
                            stall_ev[i] = (MAX_STALL > 1) && (stall_q[i] == STALL_PRE);
                        end
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        hit_any  = |(drop_ev | data_ev | stall_ev);
        sel_ch   = '0;
        sel_code = 2'd0;
        // descending scan so the lowest violating channel is the one left selected
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (drop_ev[i] || data_ev[i] || stall_ev[i]) begin
                sel_ch   = CH_W'(i);
                sel_code = data_ev[i] ? 2'd2 : (drop_ev[i] ? 2'd1 : 2'd3);
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                lat_q[i]   <= '0;
                stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                lat_q[i]   <= lat_d[i];
                stall_q[i] <= stall_d[i];
            end
        end
    end

    // clear wipes the reporting side only; protocol context above keeps running
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            err_drop   <= '0;
            err_data   <= '0;
            err_stall  <= '0;
            err_pulse  <= 1'b0;
            first_ch   <= '0;
            first_code <= 2'd0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else if (clear) begin
            err_drop   <= '0;
            err_data   <= '0;
            err_stall  <= '0;
            err_pulse  <= 1'b0;
            first_ch   <= '0;
            first_code <= 2'd0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
        end else begin
            err_drop  <= err_drop  | drop_ev;
            err_data  <= err_data  | data_ev;
            err_stall <= err_stall | stall_ev;
            err_pulse <= hit_any;
            if (first_code == 2'd0 && hit_any) begin
                first_ch   <= sel_ch;
                first_code <= sel_code;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (bus.valid[i] && bus.ready[i] && cnt_q[i] != {CNT_W{1'b1}})
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign err_any = |{err_drop, err_data, err_stall};

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        assign xfer_count[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Randomized and directed bench; a time-based reference model feeds a scoreboard queue checked each cycle.
module tb_handshake_protocol_monitor;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int MS     = 6;
    localparam int CNT_W  = 4;

    typedef struct {
        logic [3:0]  drop;
        logic [3:0]  data;
        logic [3:0]  stall;
        logic        any;
        logic        pulse;
        logic [1:0]  fch;
        logic [1:0]  fcode;
        logic [15:0] cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        ASYNCRESETN = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  err_drop, err_data, err_stall;
    logic        err_any, err_pulse;
    logic [1:0]  first_ch, first_code;
    logic [15:0] xfer_count;

    handshake_protocol_monitor_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

    handshake_protocol_monitor #(
        .N_CH(N_CH), .DATA_W(DATA_W), .MAX_STALL(MS), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bus), .clear(clear),
        .err_drop(err_drop), .err_data(err_data), .err_stall(err_stall),
        .err_any(err_any), .err_pulse(err_pulse),
        .first_ch(first_ch), .first_code(first_code), .xfer_count(xfer_count)
    );

    always #5 CLK = ~CLK;

    int passes = 0;
    int checks = 0;

    // reference model: a pending offer is remembered by the cycle it started and its payload
    bit         busy  [4];
    int         start [4];
    logic [7:0] held  [4];
    int         cyc = 0;
    exp_t       m;
    exp_t       q [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            busy[c] = 1'b0;
            start[c] = 0;
            held[c] = 8'h00;
        end
        m = '{drop: 4'h0, data: 4'h0, stall: 4'h0, any: 1'b0, pulse: 1'b0,
              fch: 2'd0, fcode: 2'd0, cnt: 16'h0};
    endtask

    task automatic model_step(input logic [3:0] v, input logic [3:0] r,
                              input logic [31:0] d, input logic clr);
        logic [3:0] dr, dt, st, x;
        bit found;
        int c4;
        dr = 0; dt = 0; st = 0; x = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy[c]) begin
                if (!v[c]) begin
                    dr[c] = 1'b1;
                    busy[c] = 1'b0;
                end else begin
                    if (d[c*8 +: 8] != held[c]) begin
                        dt[c] = 1'b1;
                        held[c] = d[c*8 +: 8];
                    end
                    if (r[c]) begin
                        x[c] = 1'b1;
                        busy[c] = 1'b0;
                    end else if (cyc - start[c] + 1 == MS) begin
                        st[c] = 1'b1;
                    end
                end
            end else if (v[c]) begin
                if (r[c]) x[c] = 1'b1;
                else begin
                    busy[c] = 1'b1;
                    start[c] = cyc;
                    held[c] = d[c*8 +: 8];
                    if (MS == 1) st[c] = 1'b1;
                end
            end
        end
        cyc++;
        if (clr) begin
            m.drop = 0; m.data = 0; m.stall = 0; m.pulse = 0;
            m.fch = 0; m.fcode = 0; m.cnt = 0;
        end else begin
            m.drop  |= dr;
            m.data  |= dt;
            m.stall |= st;
            m.pulse = |(dr | dt | st);
            for (int c = 0; c < 4; c++) begin
                c4 = int'(m.cnt[c*4 +: 4]);
                if (x[c] && c4 < 15) c4++;
                m.cnt[c*4 +: 4] = 4'(c4);
            end
            if (m.fcode == 2'd0) begin
                found = 0;
                for (int c = 0; c < 4; c++) begin
                    if (!found && (dr[c] || dt[c] || st[c])) begin
                        found = 1;
                        m.fch = 2'(c);
                        m.fcode = dt[c] ? 2'd2 : (dr[c] ? 2'd1 : 2'd3);
                    end
                end
            end
        end
        m.any = |{m.drop, m.data, m.stall};
        q.push_back(m);
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] r,
                         input logic [31:0] d, input logic clr);
        @(negedge CLK);
        bus.valid = v;
        bus.ready = r;
        bus.data  = d;
        clear     = clr;
        model_step(v, r, d, clr);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_drop"},  16'(err_drop),  16'h0);
        chk({tag, "_data"},  16'(err_data),  16'h0);
        chk({tag, "_stall"}, 16'(err_stall), 16'h0);
        chk({tag, "_any"},   16'(err_any),   16'h0);
        chk({tag, "_pulse"}, 16'(err_pulse), 16'h0);
        chk({tag, "_first"}, 16'({first_ch, first_code}), 16'h0);
        chk({tag, "_cnt"},   xfer_count,     16'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("err_drop",   16'(err_drop),   16'(e.drop));
                chk("err_data",   16'(err_data),   16'(e.data));
                chk("err_stall",  16'(err_stall),  16'(e.stall));
                chk("err_any",    16'(err_any),    16'(e.any));
                chk("err_pulse",  16'(err_pulse),  16'(e.pulse));
                chk("first_ch",   16'(first_ch),   16'(e.fch));
                chk("first_code", 16'(first_code), 16'(e.fcode));
                chk("xfer_count", xfer_count,      e.cnt);
            end
        end
    end

    initial begin : stim
        logic [3:0]  v, r;
        logic [31:0] d;
        logic        clr;
        bus.valid = 0;
        bus.ready = 0;
        bus.data  = 0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_zero("reset");
        @(negedge CLK);
        ASYNCRESETN = 1'b1;

        // T1: five clean transfers on ch0
        repeat (5) drive(4'b0001, 4'b0001, 32'h0000_0011, 1'b0);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        // T2: ch1 stalls three cycles then drops valid
        repeat (3) drive(4'b0010, 4'b0000, 32'h0000_3300, 1'b0);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        repeat (2) drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        // T3: ch2 payload changes mid-stall, then accepted
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        repeat (2) drive(4'b0100, 4'b0000, 32'h00A5_0000, 1'b0);
        drive(4'b0100, 4'b0000, 32'h005A_0000, 1'b0);
        drive(4'b0100, 4'b0100, 32'h005A_0000, 1'b0);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        // T4: ch3 held off for 20 cycles, then accepted
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        repeat (20) drive(4'b1000, 4'b0000, 32'h7700_0000, 1'b0);
        drive(4'b1000, 4'b1000, 32'h7700_0000, 1'b0);
        // T5: simultaneous drops on ch0 and ch3, then clear while ch1 waits
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        repeat (2) drive(4'b1001, 4'b0000, 32'h1100_0022, 1'b0);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        drive(4'b0010, 4'b0000, 32'h0000_4400, 1'b0);
        drive(4'b0010, 4'b0000, 32'h0000_4400, 1'b1);
        drive(4'b0010, 4'b0000, 32'h0000_4400, 1'b0);
        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        // T6: counter saturation, then reset while ch2 waits
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        repeat (20) drive(4'b0001, 4'b0001, 32'h0000_0055, 1'b0);
        repeat (2) drive(4'b0100, 4'b0000, 32'h0066_0000, 1'b0);
        @(posedge CLK);
        #3;
        ASYNCRESETN = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        bus.valid = 0;
        bus.ready = 0;
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        repeat (3) drive(4'b0000, 4'b0000, 32'h0, 1'b0);

        // randomized traffic, biased towards holding offers and occasionally violating
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) begin
                if (busy[c]) begin
                    v[c] = ($urandom_range(0, 15) != 0);
                    d[c*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : held[c];
                end else begin
                    v[c] = 1'($urandom_range(0, 1));
                    d[c*8 +: 8] = 8'($urandom);
                end
                r[c] = ($urandom_range(0, 3) == 0);
            end
            clr = ($urandom_range(0, 99) == 0);
            drive(v, r, d, clr);
        end

        drive(4'b0000, 4'b0000, 32'h0, 1'b0);
        @(posedge CLK);
        #2;
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
